// File: rtl/lib_switch_allocator_onehot.sv
// lib_switch_allocator_onehot
// Packet-granular switch allocator. Each output owns a small IDLE/LOCKED
// arbiter with a round-robin pointer. An IDLE output picks the first eligible
// requester at or after its pointer. A LOCKED output keeps routing its owner
// until that owner presents a tail flit.
//
// Handshake: i_req is a level request. A request is served when the matching
// o_sel bit rises one cycle after the sampling edge. Ownership ends at the
// edge where ce=1 and the owner's i_tail=1. A request row with more than one
// bit set is ignored for that cycle.
module lib_switch_allocator_onehot #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              ce,
    input  logic [0:N-1][0:M-1]               i_req,
    input  logic [0:N-1]                      i_tail,
    output logic [0:M-1][0:N-1]               o_sel,
    output logic [0:N-1]                      o_gnt,
    output logic [0:M-1]                      dbg_locked,
    output logic [0:M-1][$clog2(N)-1:0]       dbg_ptr
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    arb_state_e          state_q [M];
    arb_state_e          state_d [M];
    logic [PW-1:0]       ptr_q   [M];
    logic [PW-1:0]       ptr_d   [M];
    logic [PW-1:0]       owner_q [M];
    logic [PW-1:0]       owner_d [M];
    logic [0:M-1][0:N-1] sel_d;
    logic [0:N-1]        gnt_d;
    logic [0:N-1]        req_eligible;

    // An input may compete only with a one-hot row and while it holds no output.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            req_eligible[j] = $onehot(i_req[j]) && !o_gnt[j];
        end
    end

    // Per-output next state: round-robin pick when idle, tail release when locked.
    always_comb begin
        logic found;
        int   idx;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < M; i++) begin
            state_d[i] = state_q[i];
            ptr_d[i]   = ptr_q[i];
            owner_d[i] = owner_q[i];
            sel_d[i]   = o_sel[i];
        end
        for (int i = 0; i < M; i++) begin
            case (state_q[i])
                ARB_IDLE: begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        idx = (int'(ptr_q[i]) + k) % N;
                        if (!found && req_eligible[idx] && i_req[idx][i]) begin
                            found        = 1'b1;
                            state_d[i]   = ARB_LOCKED;
                            owner_d[i]   = PW'(idx);
                            ptr_d[i]     = PW'((idx + 1) % N);
                            sel_d[i]     = '0;
                            sel_d[i][idx] = 1'b1;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // Only the owner's tail ends the packet; a released output
                    // sits idle for the following cycle before re-arbitrating.
                    if (i_tail[owner_q[i]]) begin
                        state_d[i] = ARB_IDLE;
                        sel_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = ARB_IDLE;
                    sel_d[i]   = '0;
                end
            endcase
        end
        for (int j = 0; j < N; j++) begin
            gnt_d[j] = 1'b0;
            for (int i = 0; i < M; i++) begin
                gnt_d[j] = gnt_d[j] | sel_d[i][j];
            end
        end
    end

    // State, pointers and registered crossbar selects; everything holds while ce=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) begin
                state_q[i] <= ARB_IDLE;
                ptr_q[i]   <= '0;
                owner_q[i] <= '0;
            end
            o_sel <= '0;
            o_gnt <= '0;
        end else if (ce) begin
            for (int i = 0; i < M; i++) begin
                state_q[i] <= state_d[i];
                ptr_q[i]   <= ptr_d[i];
                owner_q[i] <= owner_d[i];
            end
            o_sel <= sel_d;
            o_gnt <= gnt_d;
        end
    end

    // Observation of arbiter state for checkers.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            dbg_locked[i] = (state_q[i] == ARB_LOCKED);
            dbg_ptr[i]    = ptr_q[i];
        end
    end

endmodule

// File: tb/tb_lib_switch_allocator_onehot.sv
// Directed bench for lib_switch_allocator_onehot (N=4, M=4).
module tb_lib_switch_allocator_onehot;

    localparam int N = 4;
    localparam int M = 4;

    logic                    clk;
    logic                    reset_n;
    logic                    ce;
    logic [0:N-1][0:M-1]     i_req;
    logic [0:N-1]            i_tail;
    logic [0:M-1][0:N-1]     o_sel;
    logic [0:N-1]            o_gnt;
    logic [0:M-1]            dbg_locked;
    logic [0:M-1][1:0]       dbg_ptr;

    int tests_run;
    int tests_failed;

    lib_switch_allocator_onehot #(.N(N), .M(M)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .i_req      (i_req),
        .i_tail     (i_tail),
        .o_sel      (o_sel),
        .o_gnt      (o_gnt),
        .dbg_locked (dbg_locked),
        .dbg_ptr    (dbg_ptr)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ce      = 1'b1;
        i_req   = '0;
        i_tail  = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (o_sel !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_sel: got %h expected %h", o_sel, 16'h0000);
        end
        tests_run++;
        if (o_gnt !== 4'b0000 || dbg_ptr !== 8'h00 || dbg_locked !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_state: gnt=%b ptr=%h locked=%b expected 0000/00/0000", o_gnt, dbg_ptr, dbg_locked);
        end
        // Lock output 0 to input 0, then reset mid-packet with ce low.
        i_req[0] = 4'b1000;
        tick();
        tests_run++;
        if (o_sel[0] !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_prelock: got %b expected %b", o_sel[0], 4'b1000);
        end
        ce = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (o_sel !== 16'h0000 || o_gnt !== 4'b0000 || dbg_locked !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_async: sel=%h gnt=%b locked=%b expected 0000/0000/0000", o_sel, o_gnt, dbg_locked);
        end
        i_req = '0;
        tick();
        reset_n = 1'b1;
        ce = 1'b1;
        i_req[2] = 4'b0100;
        tick();
        tests_run++;
        if (o_sel[1] !== 4'b0010 || o_gnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL reset_restart: sel1=%b gnt=%b expected 0010/0010", o_sel[1], o_gnt);
        end
        tests_run++;
        if (dbg_ptr[1] !== 2'd3 || o_sel[0] !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_restart_ptr: ptr1=%0d sel0=%b expected 3/0000", dbg_ptr[1], o_sel[0]);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_q [$];
        logic [1:0]   exp_ptr [8];
        logic [N-1:0] exp_sel;
        exp_ptr = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
        exp_q = {4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        apply_reset();
        i_req[0] = 4'b0010;
        i_req[1] = 4'b0010;
        i_req[3] = 4'b0010;
        i_tail   = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_sel = exp_q.pop_front();
            tests_run++;
            if (o_sel[2] !== exp_sel || o_gnt !== exp_sel || dbg_ptr[2] !== exp_ptr[k]) begin
                tests_failed++;
                $display("FAIL contention_step%0d: sel2=%b gnt=%b ptr2=%0d expected %b/%b/%0d",
                         k, o_sel[2], o_gnt, dbg_ptr[2], exp_sel, exp_sel, exp_ptr[k]);
            end
        end
    endtask

    task automatic test_lock();
        apply_reset();
        i_req[1] = 4'b1000;
        tick();
        tests_run++;
        if (o_sel[0] !== 4'b0100) begin
            tests_failed++;
            $display("FAIL lock_grant: got %b expected %b", o_sel[0], 4'b0100);
        end
        // Owner drops its request; a competitor requests and waves a tail.
        i_req[1] = 4'b0000;
        i_req[2] = 4'b1000;
        i_tail   = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (o_sel[0] !== 4'b0100 || o_gnt !== 4'b0100) begin
                tests_failed++;
                $display("FAIL lock_hold%0d: sel0=%b gnt=%b expected 0100/0100", k, o_sel[0], o_gnt);
            end
        end
        i_tail = 4'b0100;
        tick();
        i_tail = 4'b0000;
        tests_run++;
        if (o_sel[0] !== 4'b0000 || dbg_locked[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_release: sel0=%b locked=%b expected 0000/0", o_sel[0], dbg_locked[0]);
        end
        tick();
        tests_run++;
        if (o_sel[0] !== 4'b0010 || dbg_ptr[0] !== 2'd3) begin
            tests_failed++;
            $display("FAIL lock_next: sel0=%b ptr0=%0d expected 0010/3", o_sel[0], dbg_ptr[0]);
        end
    endtask

    task automatic test_parallel();
        apply_reset();
        i_req = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tick();
        tests_run++;
        if (o_sel !== 16'h1248 || o_gnt !== 4'b1111 || dbg_locked !== 4'b1111) begin
            tests_failed++;
            $display("FAIL parallel_grant: sel=%h gnt=%b locked=%b expected 1248/1111/1111", o_sel, o_gnt, dbg_locked);
        end
        i_tail = 4'b1111;
        tick();
        i_tail = 4'b0000;
        i_req  = '0;
        tests_run++;
        if (o_sel !== 16'h0000 || o_gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL parallel_release: sel=%h gnt=%b expected 0000/0000", o_sel, o_gnt);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        i_req[0] = 4'b1100;
        i_req[1] = 4'b1000;
        tick();
        tests_run++;
        if (o_sel !== 16'h4000 || o_gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL illegal_grant: sel=%h gnt=%b expected 4000/0100", o_sel, o_gnt);
        end
        i_tail   = 4'b0100;
        i_req[1] = 4'b0000;
        tick();
        i_tail = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests_run++;
            if (o_sel !== 16'h0000 || o_gnt[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_nogrant%0d: sel=%h gnt=%b expected 0000/0xxx", k, o_sel, o_gnt);
            end
        end
        i_req[0] = 4'b1000;
        tick();
        tests_run++;
        if (o_sel[0] !== 4'b1000 || o_gnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL illegal_legalized: sel0=%b gnt=%b expected 1000/1000", o_sel[0], o_gnt);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        i_req[3] = 4'b0100;
        tick();
        tests_run++;
        if (o_sel[1] !== 4'b0001) begin
            tests_failed++;
            $display("FAIL stall_grant: got %b expected %b", o_sel[1], 4'b0001);
        end
        ce       = 1'b0;
        i_tail   = 4'b0001;
        i_req[0] = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (o_sel !== 16'h0100 || o_gnt !== 4'b0001 || dbg_ptr[1] !== 2'd0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: sel=%h gnt=%b ptr1=%0d expected 0100/0001/0", k, o_sel, o_gnt, dbg_ptr[1]);
            end
        end
        ce = 1'b1;
        tick();
        i_tail = 4'b0000;
        tests_run++;
        if (o_sel !== 16'h0080 || o_gnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL stall_resume: sel=%h gnt=%b expected 0080/1000", o_sel, o_gnt);
        end
    endtask

    // Test sequence and final report
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        ce           = 1'b0;
        i_req        = '0;
        i_tail       = '0;
        test_reset();
        test_contention();
        test_lock();
        test_parallel();
        test_illegal();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lib_switch_allocator_onehot.md
LIB_SWITCH_ALLOCATOR_ONEHOT -- requirements
Module: lib_switch_allocator_onehot

Interface
REQ-001 Parameter N, default 4, number of switch inputs (requesters), N >= 2.
REQ-002 Parameter M, default 4, number of switch outputs (resources), M >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  clock enable; when low all state holds.
REQ-006 i_req  input  [0:N-1][0:M-1]  per-input one-hot output request; row j bit i set = input j requests output i.
REQ-007 i_tail  input  [0:N-1]  input j presents the last flit of its packet this cycle.
REQ-008 o_sel  output  [0:M-1][0:N-1]  one-hot crossbar select; o_sel[i][j]=1 routes input j to output i; all-zero = output unused.
REQ-009 o_gnt  output  [0:N-1]  input j currently owns an output; equals the OR over i of o_sel[i][j].

Function
REQ-010 The block SHALL contain one independent arbiter per output i, each with state IDLE or LOCKED, a lock-owner index and a round-robin pointer ptr[i] of width ceil(log2 N).
REQ-011 A request row with more than one bit set SHALL be treated as no request for that cycle.
REQ-012 In IDLE with ce=1, output i SHALL grant the first requesting input j found scanning ptr[i], ptr[i]+1, ... modulo N, and SHALL enter LOCKED with owner j at the clock edge.
REQ-013 On a grant, ptr[i] SHALL become (j+1) mod N at the same edge; ptr SHALL not change otherwise.
REQ-014 o_sel and o_gnt SHALL be registered; the grant is visible exactly 1 cycle after the request edge.
REQ-015 In LOCKED, o_sel[i] SHALL hold one-hot owner j regardless of i_req, until release.
REQ-016 Release: when ce=1, o_sel[i][j]=1 and i_tail[j]=1, output i SHALL return to IDLE at that edge, with o_sel[i] all-zero the next cycle.
REQ-017 An output SHALL NOT arbitrate in the cycle it releases; minimum one idle cycle between packets on the same output.
REQ-018 i_tail from a non-owner SHALL be ignored.
REQ-019 A single-flit packet (tail asserted in the first granted cycle) SHALL release after one granted cycle.
REQ-020 Since each input requests at most one output, no input SHALL ever be granted by two outputs; o_sel SHALL be one-hot or zero per row.
REQ-021 Inputs already holding a grant SHALL NOT be considered by any IDLE arbiter.
REQ-022 With ce=0, state, pointers and outputs SHALL hold; i_req and i_tail are ignored.
REQ-023 Round-robin fairness: a continuously requesting input SHALL be granted within N arbitration rounds of its output.

Reset
REQ-024 reset_n low SHALL immediately force all arbiters to IDLE, ptr to 0, o_sel and o_gnt to all-zero, independent of clk and ce.
REQ-025 Reset asserted mid-packet SHALL drop the lock; after release of reset, arbitration restarts from ptr=0 on the first edge with ce=1.

Verification (N=4, M=4)
V-1 Reset: reset_n=0 mid-stream -> o_sel=0, o_gnt=0 same cycle; after release, req input 2 -> output 1 -> o_sel[1]=0010 one cycle later.
V-2 Contention: inputs 0,1,3 all request output 2 continuously, each packet 1 flit -> grants in order 0,1,3,0 with one idle cycle between each; ptr[2] goes 1,2,0,1.
V-3 Lock: input 1 granted output 0, drops request for 3 cycles without tail -> o_sel[0]=0100 held; input 2 requesting output 0 not granted until edge after input 1 tail, then granted one idle cycle later.
V-4 Parallel: inputs 0..3 request outputs 3,2,1,0 -> all four grants same cycle, o_gnt=1111, o_sel anti-diagonal.
V-5 Illegal request: input 0 row 1100 while input 1 requests output 0 -> input 1 granted, input 0 never granted while row is multi-hot.
V-6 Stall: ce=0 for 5 cycles during a lock with i_tail=1 -> no release, outputs unchanged; ce=1 with tail -> release next edge.
